// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter slice.
// Holds the datapath widths, the CDB entry record and a helper that clears
// one branch-mask bit when a branch resolves correctly.
package cdb_arbiter_pkg;

    localparam int DATA_W    = 32;
    localparam int PREG_W    = 6;
    localparam int BMASK_W   = 4;
    localparam int BS_PTR_W  = 2;
    localparam int CDB_WIDTH = 2;

    typedef logic [DATA_W-1:0]   DATA;
    typedef logic [PREG_W-1:0]   PHYS_REG;
    typedef logic [BMASK_W-1:0]  B_MASK;
    typedef logic [BS_PTR_W-1:0] BS_PTR;

    typedef struct packed {
        logic    valid;
        DATA     result;
        PHYS_REG tagDest;
        B_MASK   bmask;
    } CDBEntry_t;

    function automatic B_MASK bmask_clear(input B_MASK m, input BS_PTR p);
        B_MASK r;
        r    = m;
        r[p] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// Combinational rotating-priority picker that selects up to two requesters.
// Ports:
//   i_req     requests, one bit per FU
//   i_ptr     index scanned first; the scan wraps modulo NUM_FU
//   o_gnt0/1  one-hot grants for the first and second pick
//   o_gnt0_v/o_gnt1_v  pick valid; the second pick is only valid with the first
//   o_idx0/o_idx1      binary index of each pick
module cdb_arbiter_rr_pick2 #(
    parameter int NUM_FU = 4,
    parameter int PTR_W  = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0] i_req,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic [NUM_FU-1:0] o_gnt0,
    output logic [NUM_FU-1:0] o_gnt1,
    output logic              o_gnt0_v,
    output logic              o_gnt1_v,
    output logic [PTR_W-1:0]  o_idx0,
    output logic [PTR_W-1:0]  o_idx1
);

    always_comb begin
        o_gnt0   = '0;
        o_gnt1   = '0;
        o_gnt0_v = 1'b0;
        o_gnt1_v = 1'b0;
        o_idx0   = '0;
        o_idx1   = '0;
        for (int off = 0; off < NUM_FU; off++) begin
            int idx;
            idx = int'(i_ptr) + off;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            if (i_req[idx]) begin
                if (!o_gnt0_v) begin
                    o_gnt0_v    = 1'b1;
                    o_gnt0[idx] = 1'b1;
                    o_idx0      = PTR_W'(idx);
                end else if (!o_gnt1_v) begin
                    o_gnt1_v    = 1'b1;
                    o_gnt1[idx] = 1'b1;
                    o_idx1      = PTR_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: collects heads of NUM_FU functional-unit output buffers and
// broadcasts up to two of them per cycle on the common data bus.
// Ports:
//   i_clk, i_rst_n            clock and asynchronous active-low reset
//   i_fub_valid/result/tagDest/bmask   buffer head contents per FU
//   i_br_branch_resolved, i_br_pred_wrong, i_br_bs_ptr   branch resolution
//   o_cdb_stall               per-FU hold request (combinational)
//   o_cdb_valid/result/tag/bmask      registered broadcast slots
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_FU-1:0]                i_fub_valid,
    input  logic [NUM_FU-1:0][DATA_W-1:0]    i_fub_result,
    input  logic [NUM_FU-1:0][PREG_W-1:0]    i_fub_tagDest,
    input  logic [NUM_FU-1:0][BMASK_W-1:0]   i_fub_bmask,
    input  logic                             i_br_branch_resolved,
    input  logic                             i_br_pred_wrong,
    input  logic [BS_PTR_W-1:0]              i_br_bs_ptr,
    output logic [NUM_FU-1:0]                o_cdb_stall,
    output logic [CDB_WIDTH-1:0]             o_cdb_valid,
    output logic [CDB_WIDTH-1:0][DATA_W-1:0] o_cdb_result,
    output logic [CDB_WIDTH-1:0][PREG_W-1:0] o_cdb_tag,
    output logic [CDB_WIDTH-1:0][BMASK_W-1:0] o_cdb_bmask
);

    localparam int PTR_W = $clog2(NUM_FU);

    logic [PTR_W-1:0] r_ptr;
    CDBEntry_t        r_out [CDB_WIDTH];

    logic              w_mispredict;
    logic              w_correct;
    logic [NUM_FU-1:0] w_squash;
    logic [NUM_FU-1:0] w_elig;
    logic [NUM_FU-1:0] w_req;
    logic [NUM_FU-1:0] w_gnt0;
    logic [NUM_FU-1:0] w_gnt1;
    logic              w_gnt0_v;
    logic              w_gnt1_v;
    logic [PTR_W-1:0]  w_idx0;
    logic [PTR_W-1:0]  w_idx1;
    logic [PTR_W-1:0]  w_last;
    logic [PTR_W-1:0]  w_ptr_nxt;
    CDBEntry_t         w_cap [CDB_WIDTH];

    assign w_mispredict = i_br_branch_resolved & i_br_pred_wrong;
    assign w_correct    = i_br_branch_resolved & ~i_br_pred_wrong;

    always_comb begin
        w_squash = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_squash[i] = w_mispredict & i_fub_bmask[i][i_br_bs_ptr];
        end
    end

    assign w_elig = i_fub_valid & ~w_squash;
    // Grants are suppressed while reset is held so that every eligible head stalls.
    assign w_req  = w_elig & {NUM_FU{i_rst_n}};

    cdb_arbiter_rr_pick2 #(
        .NUM_FU (NUM_FU),
        .PTR_W  (PTR_W)
    ) u_pick (
        .i_req    (w_req),
        .i_ptr    (r_ptr),
        .o_gnt0   (w_gnt0),
        .o_gnt1   (w_gnt1),
        .o_gnt0_v (w_gnt0_v),
        .o_gnt1_v (w_gnt1_v),
        .o_idx0   (w_idx0),
        .o_idx1   (w_idx1)
    );

    assign o_cdb_stall = w_elig & ~(w_gnt0 | w_gnt1);

    assign w_last    = w_gnt1_v ? w_idx1 : w_idx0;
    assign w_ptr_nxt = (w_last == PTR_W'(NUM_FU - 1)) ? '0 : w_last + 1'b1;

    always_comb begin
        w_cap[0].valid   = w_gnt0_v;
        w_cap[0].result  = i_fub_result[w_idx0];
        w_cap[0].tagDest = i_fub_tagDest[w_idx0];
        w_cap[0].bmask   = w_correct ? bmask_clear(i_fub_bmask[w_idx0], i_br_bs_ptr)
                                     : i_fub_bmask[w_idx0];
        w_cap[1].valid   = w_gnt1_v;
        w_cap[1].result  = i_fub_result[w_idx1];
        w_cap[1].tagDest = i_fub_tagDest[w_idx1];
        w_cap[1].bmask   = w_correct ? bmask_clear(i_fub_bmask[w_idx1], i_br_bs_ptr)
                                     : i_fub_bmask[w_idx1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                r_out[k] <= '0;
            end
        end else begin
            if (w_gnt0_v) r_ptr <= w_ptr_nxt;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                r_out[k] <= w_cap[k];
            end
        end
    end

    // A branch resolving during the broadcast cycle acts on the registered
    // entries too: a mispredict kills dependent slots, a correct resolve
    // hides the resolved bit from consumers.
    always_comb begin
        for (int k = 0; k < CDB_WIDTH; k++) begin
            o_cdb_valid[k]  = r_out[k].valid & ~(w_mispredict & r_out[k].bmask[i_br_bs_ptr]);
            o_cdb_result[k] = r_out[k].result;
            o_cdb_tag[k]    = r_out[k].tagDest;
            o_cdb_bmask[k]  = w_correct ? bmask_clear(r_out[k].bmask, i_br_bs_ptr)
                                        : r_out[k].bmask;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int NF = 4;

    logic              clk = 1'b0;
    logic              i_rst_n;
    logic [NF-1:0]     i_fub_valid;
    logic [NF-1:0][31:0] i_fub_result;
    logic [NF-1:0][5:0]  i_fub_tagDest;
    logic [NF-1:0][3:0]  i_fub_bmask;
    logic              i_br_res;
    logic              i_br_wrong;
    logic [1:0]        i_br_ptr;
    logic [NF-1:0]     o_cdb_stall;
    logic [1:0]        o_cdb_valid;
    logic [1:0][31:0]  o_cdb_result;
    logic [1:0][5:0]   o_cdb_tag;
    logic [1:0][3:0]   o_cdb_bmask;

    cdb_arbiter #(.NUM_FU(NF)) dut (
        .i_clk                (clk),
        .i_rst_n              (i_rst_n),
        .i_fub_valid          (i_fub_valid),
        .i_fub_result         (i_fub_result),
        .i_fub_tagDest        (i_fub_tagDest),
        .i_fub_bmask          (i_fub_bmask),
        .i_br_branch_resolved (i_br_res),
        .i_br_pred_wrong      (i_br_wrong),
        .i_br_bs_ptr          (i_br_ptr),
        .o_cdb_stall          (o_cdb_stall),
        .o_cdb_valid          (o_cdb_valid),
        .o_cdb_result         (o_cdb_result),
        .o_cdb_tag            (o_cdb_tag),
        .o_cdb_bmask          (o_cdb_bmask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       v;
        logic [1:0][31:0] res;
        logic [1:0][5:0]  tag;
        logic [1:0][3:0]  bm;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    int   m_ptr;
    int   n_cmp = 0;
    int   n_bad = 0;

    // staged stimulus, applied just after the next rising edge
    logic              s_rst;
    logic [NF-1:0]     s_v;
    logic [NF-1:0][31:0] s_res;
    logic [NF-1:0][5:0]  s_tag;
    logic [NF-1:0][3:0]  s_bm;
    logic              s_bres, s_bwrong;
    logic [1:0]        s_bptr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t empty_exp();
        exp_t e;
        e.v = '0; e.res = '0; e.tag = '0; e.bm = '0;
        return e;
    endfunction

    // Reference: list eligible FUs in rotated order, grant the first two.
    task automatic model_step(output logic [NF-1:0] exp_stall);
        int order[$];
        logic [NF-1:0] elig, gnt;
        for (int i = 0; i < NF; i++)
            elig[i] = s_v[i] && !(s_bres && s_bwrong && s_bm[i][s_bptr]);
        pend = empty_exp();
        gnt  = '0;
        if (s_rst) begin
            for (int off = 0; off < NF; off++)
                if (elig[(m_ptr + off) % NF]) order.push_back((m_ptr + off) % NF);
            for (int k = 0; k < 2 && k < order.size(); k++) begin
                int f = order[k];
                gnt[f]     = 1'b1;
                pend.v[k]  = 1'b1;
                pend.res[k] = s_res[f];
                pend.tag[k] = s_tag[f];
                pend.bm[k]  = s_bm[f];
                if (s_bres && !s_bwrong) pend.bm[k][s_bptr] = 1'b0;
                m_ptr = (f + 1) % NF;
            end
        end else begin
            m_ptr = 0;
        end
        exp_stall = elig & ~gnt;
    endtask

    task automatic cycle();
        logic [NF-1:0] es;
        @(posedge clk);
        q.push_back(pend);
        #1;
        i_rst_n       = s_rst;
        i_fub_valid   = s_v;
        i_fub_result  = s_res;
        i_fub_tagDest = s_tag;
        i_fub_bmask   = s_bm;
        i_br_res      = s_bres;
        i_br_wrong    = s_bwrong;
        i_br_ptr      = s_bptr;
        if (!s_rst) q.delete();
        model_step(es);
        #1;
        chk("stall", 64'(o_cdb_stall), 64'(es));
    endtask

    task automatic clr_all();
        s_v = '0; s_bm = '0; s_bres = 1'b0; s_bwrong = 1'b0; s_bptr = '0;
    endtask

    task automatic set_fu(input int i, input logic [5:0] tag, input logic [3:0] bm);
        s_v[i]   = 1'b1;
        s_tag[i] = tag;
        s_bm[i]  = bm;
        s_res[i] = $urandom;
    endtask

    // Monitor: compares the registered broadcast against the queued capture,
    // applying whatever branch resolution is visible this cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            for (int k = 0; k < 2; k++) begin
                logic       ev;
                logic [3:0] ebm;
                ev  = e.v[k] && !(i_br_res && i_br_wrong && e.bm[k][i_br_ptr]);
                ebm = e.bm[k];
                if (i_br_res && !i_br_wrong) ebm[i_br_ptr] = 1'b0;
                chk($sformatf("cdb_valid[%0d]", k), 64'(o_cdb_valid[k]), 64'(ev));
                if (ev) begin
                    chk($sformatf("cdb_tag[%0d]", k), 64'(o_cdb_tag[k]), 64'(e.tag[k]));
                    chk($sformatf("cdb_result[%0d]", k), 64'(o_cdb_result[k]), 64'(e.res[k]));
                    chk($sformatf("cdb_bmask[%0d]", k), 64'(o_cdb_bmask[k]), 64'(ebm));
                end
            end
        end
    end

    initial begin
        i_rst_n = 1'b0; i_fub_valid = '0; i_fub_result = '0; i_fub_tagDest = '0;
        i_fub_bmask = '0; i_br_res = 1'b0; i_br_wrong = 1'b0; i_br_ptr = '0;
        s_rst = 1'b0; s_res = '0; s_tag = '0;
        clr_all();
        m_ptr = 0;
        pend  = empty_exp();
        #1;
        chk("reset_valid", 64'(o_cdb_valid), 64'd0);
        set_fu(1, 6'd9, 4'd0);
        cycle();
        chk("reset_stall_eq_elig", 64'(o_cdb_stall), 64'b0010);
        clr_all();
        cycle();
        s_rst = 1'b1;

        // three requesters from rr_ptr=0
        set_fu(0, 6'd5, 4'd0); set_fu(1, 6'd6, 4'd0); set_fu(2, 6'd7, 4'd0);
        cycle();
        chk("three_req_stall", 64'(o_cdb_stall), 64'b0100);
        clr_all();
        cycle();
        chk("three_req_valid", 64'(o_cdb_valid), 64'b11);
        chk("three_req_tag0", 64'(o_cdb_tag[0]), 64'd5);
        chk("three_req_tag1", 64'(o_cdb_tag[1]), 64'd6);

        // ptr is 2 now; a lone FU0 moves it to 1
        set_fu(0, 6'd3, 4'd0);
        cycle();
        clr_all();

        // squash of FU1 on mispredict of bit 3, ptr=1
        set_fu(1, 6'd11, 4'b1000); set_fu(2, 6'd12, 4'b0000);
        s_bres = 1'b1; s_bwrong = 1'b1; s_bptr = 2'd3;
        cycle();
        chk("squash_stall", 64'(o_cdb_stall), 64'b0000);
        clr_all();
        cycle();
        chk("squash_valid", 64'(o_cdb_valid), 64'b01);
        chk("squash_tag0", 64'(o_cdb_tag[0]), 64'd12);

        // wrap: ptr=3, FU3 and FU0
        set_fu(3, 6'd33, 4'd0); set_fu(0, 6'd30, 4'd0);
        cycle();
        clr_all();
        set_fu(2, 6'd22, 4'd0);
        cycle();
        chk("wrap_tag0", 64'(o_cdb_tag[0]), 64'd33);
        chk("wrap_tag1", 64'(o_cdb_tag[1]), 64'd30);
        chk("wrap_ptr", 64'(m_ptr), 64'd3);
        clr_all();
        cycle();
        chk("single_valid", 64'(o_cdb_valid), 64'b01);

        // correct resolve at capture, then again in the broadcast cycle
        set_fu(0, 6'd40, 4'b0101);
        s_bres = 1'b1; s_bwrong = 1'b0; s_bptr = 2'd2;
        cycle();
        clr_all();
        s_bres = 1'b1; s_bwrong = 1'b0; s_bptr = 2'd0;
        cycle();
        chk("resolve_bmask", 64'(o_cdb_bmask[0]), 64'd0);
        clr_all();

        // late mispredict on a broadcasting entry
        set_fu(1, 6'd50, 4'b0010);
        cycle();
        clr_all();
        s_bres = 1'b1; s_bwrong = 1'b1; s_bptr = 2'd1;
        cycle();
        chk("late_mispredict_valid", 64'(o_cdb_valid[0]), 64'd0);
        clr_all();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            s_v = NF'($urandom);
            for (int i = 0; i < NF; i++) begin
                s_res[i] = $urandom;
                s_tag[i] = 6'($urandom);
                s_bm[i]  = 4'($urandom & $urandom);
            end
            s_bres   = ($urandom_range(0, 9) < 3);
            s_bwrong = $urandom_range(0, 1) == 1;
            s_bptr   = 2'($urandom);
            cycle();
        end

        // reset while both slots broadcast
        clr_all();
        for (int i = 0; i < NF; i++) set_fu(i, 6'(i + 1), 4'd0);
        cycle();
        clr_all();
        cycle();
        chk("pre_reset_valid", 64'(o_cdb_valid), 64'b11);
        #1;
        i_rst_n = 1'b0;
        s_rst   = 1'b0;
        q.delete();
        pend  = empty_exp();
        m_ptr = 0;
        #1;
        chk("async_reset_valid", 64'(o_cdb_valid), 64'd0);
        cycle();
        s_rst = 1'b1;
        set_fu(0, 6'd60, 4'd0); set_fu(3, 6'd63, 4'd0);
        cycle();
        chk("post_reset_stall", 64'(o_cdb_stall), 64'b0000);
        clr_all();
        cycle();
        chk("post_reset_tag0", 64'(o_cdb_tag[0]), 64'd60);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
